ps2_scancode_receiver: RTL
==========================

# ps2_scancode_receiver

Receives serial frames from a PS/2 keyboard and turns them into single-cycle scan-code strobes on an 8-bit `key` bus. `key` is 0x00 when idle and carries a make code for exactly one `clk` cycle per key press. The block sits between the keyboard pins and the entry controllers, which consume `key` directly and treat any non-zero value as a new key press. It also handles break and extended-code sequences, checks parity, and recovers from truncated frames.

## Interface
- `FILTER_LEN`, default 8: number of consecutive identical `clk` samples required before a new `ps2Clk` level is accepted.
- `TIMEOUT_CYCLES`, default 100000: number of `clk` cycles with no filtered falling edge, in the middle of a frame, before the frame is abandoned (1 ms at 100 MHz).
- `clk` input 1: system clock. This is the only clock. All logic is clocked on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `ps2Clk` input 1: keyboard clock. It is asynchronous to `clk`.
- `ps2Data` input 1: keyboard data. It is asynchronous to `clk`.
- `key` output 8: make code, valid for one cycle; 0x00 at all other times.
- `frameError` output 1: one-cycle pulse on a parity error, a bad stop bit, or a timeout.
- `busy` output 1: high from start-bit acceptance until the frame ends.

## Operation
- **Input synchronisation:** `ps2Clk` and `ps2Data` each pass through two flip-flops.
- **Clock filter:** the synchronised `ps2Clk` is filtered. The filtered level changes only after `FILTER_LEN` consecutive samples at the new level. A filtered 1→0 transition is a "fall".
- **Data sampling:** the synchronised `ps2Data` is sampled on the same cycle the fall is detected.
- **Frame format:** start bit (0), 8 data bits LSB first, odd parity bit, stop bit (1).
- **Frame FSM, states IDLE → DATA → PARITY → STOP → IDLE:**
  - IDLE: a fall with data=0 moves to DATA and clears the 3-bit bit counter. A fall with data=1 is ignored.
  - DATA: each fall shifts the data bit into bit 7 of an 8-bit shift register. After the 8th bit (counter wraps 7→0), move to PARITY.
  - PARITY: latch the parity bit, then move to STOP.
  - STOP: on a fall, go to IDLE. The frame is good only if data=1 and the XOR of the 8 data bits and the parity bit is 1. Otherwise pulse `frameError`.
- **Timeout:** in any state other than IDLE, a counter counts cycles since the last fall. When it reaches `TIMEOUT_CYCLES`, go to IDLE and pulse `frameError`. The counter clears on every fall and in IDLE.
- **Sequence tracking**, applied to good frames only:
  - 0xF0 sets the `breakPending` flag. Nothing is emitted.
  - 0xE0 sets the `extPending` flag. Nothing is emitted.
  - Any other code with `breakPending`=1 emits nothing and clears both flags.
  - Any other code with `breakPending`=0 emits the code on `key` for one cycle and clears both flags.
  - Typematic repeats from the keyboard are emitted each time they arrive.
- **Errored frames:** emit nothing, clear both flags, and leave no partial state behind.

## Timing
- **Reset values:**
  - Outputs: `key`=0x00, `frameError`=0, `busy`=0.
  - Internal state: FSM in IDLE; flags, shift register, bit counter and timeout counter all 0; filtered `ps2Clk`=1.
- **Reset mid-frame:** the partial frame is discarded. The next frame starts fresh, with no error pulse.
- **Output latency:**
  - `key` is registered. It is non-zero on the cycle after the cycle in which the stop-bit fall is detected, and returns to 0x00 on the following cycle.
  - `frameError` follows the same timing as `key`.
  - `key` and `frameError` are never both asserted in the same cycle.
- **Input-to-fall latency:** a real `ps2Clk` falling edge is detected 2 + `FILTER_LEN` cycles after it reaches the pin, ±1 cycle.
- **Glitch rejection:** a `ps2Clk` glitch shorter than `FILTER_LEN` cycles produces no fall.
- **`busy`:** rises on the cycle after start-bit acceptance. It falls in the same cycle that `key` or `frameError` asserts.
- **Timeout vs. fall in the same cycle:** the fall wins and the timeout counter clears.
- **Minimum frame spacing:** no gap is required between a stop bit and the next start bit. A back-to-back frame is accepted.

## Test plan
- **Good make code:** frame 0x1C (bits 0,0,1,1,1,0,0,0; parity 0; stop 1) at a 50 µs bit period → `key`=0x1C for exactly 1 cycle, `frameError` stays 0, `busy` is low afterwards.
- **Break sequence suppressed:** frames 0xF0 (parity 1) then 0x1C (parity 0) → `key` stays 0x00 throughout. A following frame 0x24 (parity 1) → `key`=0x24 for 1 cycle.
- **Extended code:** frames 0xE0 (parity 0) then 0x74 (parity 1) → `key`=0x74 once. The sequence E0, F0, 74 → no `key` output.
- **Parity and stop errors:**
  - 0x1C sent with parity 1 → `frameError` pulses for 1 cycle, `key` stays 0.
  - 0x1C sent with stop bit 0 → same response.
  - A subsequent good 0x43 → `key`=0x43.
- **Timeout recovery:** send a start bit plus 4 data bits, then hold `ps2Clk` high → `frameError` pulses exactly `TIMEOUT_CYCLES` (+1) cycles after the last fall, and `busy` drops. A subsequent good 0x24 is decoded correctly.
- **Robustness:**
  - `ps2Clk` low glitches of `FILTER_LEN`−2 cycles injected during a 0x32 frame → `key`=0x32.
  - `reset` asserted for 1 cycle after the 5th bit of a frame → no `key` or `frameError` output. The next good 0x2B frame → `key`=0x2B.

Source files
------------

// File: rtl/ps2_scancode_receiver_if.sv
// Signal bundle between the PS/2 pins, the receiver and the entry controllers.
// The receiver uses the slave modport; the keyboard side uses the master modport.
interface ps2_scancode_receiver_if;
  logic       ps2Clk;
  logic       ps2Data;
  logic [7:0] key;
  logic       frameError;
  logic       busy;

  modport master (
    output ps2Clk,
    output ps2Data,
    input  key,
    input  frameError,
    input  busy
  );

  modport slave (
    input  ps2Clk,
    input  ps2Data,
    output key,
    output frameError,
    output busy
  );
endinterface

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard frame receiver: synchronises and filters the pins, decodes
// 11-bit frames and emits make codes as one-cycle strobes on key.
module ps2_scancode_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  ps2_scancode_receiver_if.slave  ps2_if
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  logic          ps2_clk_meta_q,  ps2_clk_meta_d;
  logic          ps2_clk_sync_q,  ps2_clk_sync_d;
  logic          ps2_data_meta_q, ps2_data_meta_d;
  logic          ps2_data_sync_q, ps2_data_sync_d;
  logic          filt_clk_q,      filt_clk_d;
  logic [FW-1:0] filt_cnt_q,      filt_cnt_d;
  state_e        state_q,         state_d;
  logic [2:0]    bit_cnt_q,       bit_cnt_d;
  logic [7:0]    shift_q,         shift_d;
  logic          parity_q,        parity_d;
  logic [TW-1:0] to_cnt_q,        to_cnt_d;
  logic          break_q,         break_d;
  logic          ext_q,           ext_d;
  logic [7:0]    key_q,           key_d;
  logic          frame_err_q,     frame_err_d;

  logic fall;
  logic frame_done;
  logic frame_bad;
  logic timed_out;

  // Synchroniser and clock filter: the filtered level only moves after
  // FILTER_LEN consecutive synchronised samples disagree with it.
  always_comb begin : filter_comb
    // NOTE: every signal written in an always_comb gets a default first so no path leaves it unassigned (no latch).
    ps2_clk_meta_d  = ps2_if.ps2Clk;
    ps2_clk_sync_d  = ps2_clk_meta_q;
    ps2_data_meta_d = ps2_if.ps2Data;
    ps2_data_sync_d = ps2_data_meta_q;
    filt_clk_d      = filt_clk_q;
    filt_cnt_d      = '0;
    if (ps2_clk_sync_q != filt_clk_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_clk_d = ps2_clk_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end
    fall = filt_clk_q & ~filt_clk_d;
  end

  always_comb begin : frame_comb
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    break_d     = break_q;
    ext_d       = ext_q;
    key_d       = 8'h00;
    frame_err_d = 1'b0;
    frame_done  = 1'b0;
    frame_bad   = 1'b0;

    if (state_q == S_IDLE || fall) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (fall && !ps2_data_sync_q) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      S_DATA: begin
        if (fall) begin
          shift_d   = {ps2_data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (fall) begin
          parity_d = ps2_data_sync_q;
          state_d  = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          frame_done = 1'b1;
          frame_bad  = !(ps2_data_sync_q && (^{shift_q, parity_q}));
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A fall in the same cycle as the last timeout count keeps the frame alive.
    timed_out = (state_q != S_IDLE) && !fall && (to_cnt_q == TO_LAST);

    if (frame_done && !frame_bad) begin
      if (shift_q == 8'hF0) begin
        break_d = 1'b1;
      end else if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else begin
        key_d   = break_q ? 8'h00 : shift_q;
        break_d = 1'b0;
        ext_d   = 1'b0;
      end
    end

    if (frame_bad || timed_out) begin
      frame_err_d = 1'b1;
      break_d     = 1'b0;
      ext_d       = 1'b0;
    end

    // Every return to IDLE wipes the frame datapath so nothing leaks into the next frame.
    if (frame_done || timed_out) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
      parity_d  = 1'b0;
      to_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      ps2_clk_meta_q  <= 1'b1;
      ps2_clk_sync_q  <= 1'b1;
      ps2_data_meta_q <= 1'b1;
      ps2_data_sync_q <= 1'b1;
      filt_clk_q      <= 1'b1;
      filt_cnt_q      <= '0;
      state_q         <= S_IDLE;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      parity_q        <= 1'b0;
      to_cnt_q        <= '0;
      break_q         <= 1'b0;
      ext_q           <= 1'b0;
      key_q           <= 8'h00;
      frame_err_q     <= 1'b0;
    end else begin
      ps2_clk_meta_q  <= ps2_clk_meta_d;
      ps2_clk_sync_q  <= ps2_clk_sync_d;
      ps2_data_meta_q <= ps2_data_meta_d;
      ps2_data_sync_q <= ps2_data_sync_d;
      filt_clk_q      <= filt_clk_d;
      filt_cnt_q      <= filt_cnt_d;
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      parity_q        <= parity_d;
      to_cnt_q        <= to_cnt_d;
      break_q         <= break_d;
      ext_q           <= ext_d;
      key_q           <= key_d;
      frame_err_q     <= frame_err_d;
    end
  end

  assign ps2_if.key        = key_q;
  assign ps2_if.frameError = frame_err_q;
  assign ps2_if.busy       = (state_q != S_IDLE);

endmodule
